// File: rtl/dcache_mem_arbiter.sv
// rtl/dcache_mem_arbiter.sv - round-robin sharing of memory channels among dcache miss/writeback ports
//
// Each of NUM_CHANNELS channels runs its own small FSM: it claims one pending,
// unclaimed consumer, forwards that consumer's read or writeback request to
// memory, relays the response, and releases the claim once the consumer drops
// its valid. A shared round-robin pointer sets where the scan for the next
// consumer starts, so no consumer starves.
//
// Build option: define DCACHE_ARB_WRITE_PRIORITY_EN to make an idle channel look
// for writeback-pending consumers first and only then for reads, so evictions
// drain before fills. Without it, reads and writes share one round-robin pass.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   consumer_read_valid/address     per-consumer fill request (in)
//   consumer_read_ready/data        per-consumer fill completion and data (out)
//   consumer_write_valid/address/data  per-consumer writeback request (in)
//   consumer_write_ready            per-consumer writeback completion (out)
//   mem_read_valid/address          per-channel memory read request (out)
//   mem_read_ready/data             per-channel memory read response (in)
//   mem_write_valid/address/data    per-channel memory write request (out)
//   mem_write_ready                 per-channel memory write acceptance (in)
module dcache_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_e;

  state_e                                  state_q [NUM_CHANNELS];
  state_e                                  state_d [NUM_CHANNELS];
  logic [CW-1:0]                           owner_q [NUM_CHANNELS];
  logic [CW-1:0]                           owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
  logic [CW-1:0]                           rr_q, rr_d;

  logic [NUM_CONSUMERS-1:0]                c_rd_ready_q, c_rd_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_rd_data_q, c_rd_data_d;
  logic [NUM_CONSUMERS-1:0]                c_wr_ready_q, c_wr_ready_d;
  logic [NUM_CHANNELS-1:0]                 m_rd_valid_q, m_rd_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_rd_addr_q, m_rd_addr_d;
  logic [NUM_CHANNELS-1:0]                 m_wr_valid_q, m_wr_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_wr_addr_q, m_wr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_wr_data_q, m_wr_data_d;

  // First candidate at or after 'start' in circular order; MSB flags a hit.
  // Walking the offsets downwards lets the smallest offset overwrite last.
  function automatic logic [CW:0] rr_find(input logic [NUM_CONSUMERS-1:0] cand,
                                          input logic [CW-1:0] start);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_CONSUMERS;
      if (cand[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  logic [NUM_CONSUMERS-1:0] taken;  // consumers granted by lower channels this cycle
  logic [NUM_CONSUMERS-1:0] avail;
  logic [CW:0]              hit;
  logic [CW-1:0]            g;
  logic [CW-1:0]            o;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    claim_d      = claim_q;
    rr_d         = rr_q;
    c_rd_ready_d = c_rd_ready_q;
    c_rd_data_d  = c_rd_data_q;
    c_wr_ready_d = c_wr_ready_q;
    m_rd_valid_d = m_rd_valid_q;
    m_rd_addr_d  = m_rd_addr_q;
    m_wr_valid_d = m_wr_valid_q;
    m_wr_addr_d  = m_wr_addr_q;
    m_wr_data_d  = m_wr_data_q;
    taken        = '0;
    avail        = '0;
    hit          = '0;
    g            = '0;
    o            = '0;

    // Channel 0 arbitrates first; higher channels see its grant through 'taken'.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      o = owner_q[ch];
      case (state_q[ch])
        IDLE: begin
          avail = (consumer_read_valid | consumer_write_valid) & ~claim_q & ~taken;
`ifdef DCACHE_ARB_WRITE_PRIORITY_EN
          hit = rr_find(consumer_write_valid & avail, rr_q);
          if (!hit[CW]) hit = rr_find(avail, rr_q);
`else
          hit = rr_find(avail, rr_q);
`endif
          if (hit[CW]) begin
            g           = hit[CW-1:0];
            taken[g]    = 1'b1;
            claim_d[g]  = 1'b1;
            owner_d[ch] = g;
            // Later channels overwrite this, so the pointer follows the last grant.
            rr_d        = (g == CW'(NUM_CONSUMERS - 1)) ? '0 : g + CW'(1);
            if (consumer_write_valid[g]) begin
              m_wr_valid_d[ch] = 1'b1;
              m_wr_addr_d[ch]  = consumer_write_address[g];
              m_wr_data_d[ch]  = consumer_write_data[g];
              state_d[ch]      = WRITE_WAITING;
            end else begin
              m_rd_valid_d[ch] = 1'b1;
              m_rd_addr_d[ch]  = consumer_read_address[g];
              state_d[ch]      = READ_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            m_rd_valid_d[ch] = 1'b0;
            c_rd_ready_d[o]  = 1'b1;
            c_rd_data_d[o]   = mem_read_data[ch];
            state_d[ch]      = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            m_wr_valid_d[ch] = 1'b0;
            c_wr_ready_d[o]  = 1'b1;
            state_d[ch]      = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[o]) begin
            c_rd_ready_d[o] = 1'b0;
            claim_d[o]      = 1'b0;
            state_d[ch]     = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[o]) begin
            c_wr_ready_d[o] = 1'b0;
            claim_d[o]      = 1'b0;
            state_d[ch]     = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
      end
      claim_q      <= '0;
      rr_q         <= '0;
      c_rd_ready_q <= '0;
      c_rd_data_q  <= '0;
      c_wr_ready_q <= '0;
      m_rd_valid_q <= '0;
      m_rd_addr_q  <= '0;
      m_wr_valid_q <= '0;
      m_wr_addr_q  <= '0;
      m_wr_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      claim_q      <= claim_d;
      rr_q         <= rr_d;
      c_rd_ready_q <= c_rd_ready_d;
      c_rd_data_q  <= c_rd_data_d;
      c_wr_ready_q <= c_wr_ready_d;
      m_rd_valid_q <= m_rd_valid_d;
      m_rd_addr_q  <= m_rd_addr_d;
      m_wr_valid_q <= m_wr_valid_d;
      m_wr_addr_q  <= m_wr_addr_d;
      m_wr_data_q  <= m_wr_data_d;
    end
  end

  assign consumer_read_ready  = c_rd_ready_q;
  assign consumer_read_data   = c_rd_data_q;
  assign consumer_write_ready = c_wr_ready_q;
  assign mem_read_valid       = m_rd_valid_q;
  assign mem_read_address     = m_rd_addr_q;
  assign mem_write_valid      = m_wr_valid_q;
  assign mem_write_address    = m_wr_addr_q;
  assign mem_write_data       = m_wr_data_q;

endmodule
